// File: rtl/i2c_txn_arbiter.sv
// Round-robin owner of a shared I2C op engine: sequences START, address byte,
// payload bytes and STOP for the granted requester, then holds the bus idle.
module i2c_txn_arbiter #(
   parameter int         NUM_REQ    = 2,
   parameter logic [6:0] DEV_ADDR   = 7'h72,
   parameter int         GAP_CYCLES = 500
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*4-1:0] req_len,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [3:0]           byte_idx,
   output logic [NUM_REQ-1:0]   txn_done,
   output logic [NUM_REQ-1:0]   txn_err,
   output logic                 busy,
   output logic                 op_valid,
   output logic [1:0]           op_code,
   output logic [7:0]           op_data,
   input  logic                 op_done,
   input  logic                 op_nak,
   output logic [2:0]           dbg_state
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_BYTE  = 2'd1;
   localparam logic [1:0] OP_STOP  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t          state;
   logic [OW-1:0]   owner;
   logic [OW-1:0]   ptr;
   logic [OW-1:0]   pick;
   logic            pick_ok;
   logic [3:0]      len;
   logic            err;
   logic [GW-1:0]   gap_cnt;
   int              rr_k;

   // First asserted request at or after the round-robin pointer, wrapping.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      rr_k    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_k = int'(ptr) + i;
         if (rr_k >= NUM_REQ) rr_k = rr_k - NUM_REQ;
         if (!pick_ok && req[rr_k]) begin
            pick_ok = 1'b1;
            pick    = OW'(rr_k);
         end
      end
   end

   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

   // Engine handshake: op_valid rises the cycle after a state is entered and
   // holds op_code/op_data until op_done is seen; it drops the following cycle,
   // so op_done while op_valid is low never advances the sequence.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         owner    <= '0;
         ptr      <= '0;
         len      <= '0;
         err      <= 1'b0;
         gap_cnt  <= '0;
         grant    <= '0;
         byte_idx <= '0;
         txn_done <= '0;
         txn_err  <= '0;
         op_valid <= 1'b0;
         op_code  <= '0;
         op_data  <= '0;
      end else begin
         txn_done <= '0;
         txn_err  <= '0;
         case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  owner <= pick;
                  len   <= req_len[pick*4 +: 4];
                  grant <= NUM_REQ'(1) << pick;
                  ptr   <= (pick == OW'(NUM_REQ-1)) ? '0 : pick + 1'b1;
                  state <= S_START;
               end
            end
            S_START: begin
               if (!op_valid) begin
                  op_valid <= 1'b1;
                  op_code  <= OP_START;
                  op_data  <= '0;
               end else if (op_done) begin
                  op_valid <= 1'b0;
                  state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (!op_valid) begin
                  op_valid <= 1'b1;
                  op_code  <= OP_BYTE;
                  op_data  <= {DEV_ADDR, 1'b0};
               end else if (op_done) begin
                  op_valid <= 1'b0;
                  if (op_nak) begin
                     err   <= 1'b1;
                     state <= S_STOP;
                  end else if (len == 4'd0) begin
                     state <= S_STOP;
                  end else begin
                     byte_idx <= '0;
                     state    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (!op_valid) begin
                  op_valid <= 1'b1;
                  op_code  <= OP_BYTE;
                  op_data  <= req_data[owner*8 +: 8];
               end else if (op_done) begin
                  op_valid <= 1'b0;
                  if (op_nak) begin
                     err      <= 1'b1;
                     byte_idx <= '0;
                     state    <= S_STOP;
                  end else if (byte_idx == len - 4'd1) begin
                     byte_idx <= '0;
                     state    <= S_STOP;
                  end else begin
                     byte_idx <= byte_idx + 4'd1;
                  end
               end
            end
            S_STOP: begin
               if (!op_valid) begin
                  op_valid <= 1'b1;
                  op_code  <= OP_STOP;
                  op_data  <= '0;
               end else if (op_done) begin
                  op_valid        <= 1'b0;
                  txn_done[owner] <= 1'b1;
                  txn_err[owner]  <= err;
                  grant           <= '0;
                  err             <= 1'b0;
                  gap_cnt         <= '0;
                  state           <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES-1)) begin
                  gap_cnt <= '0;
                  state   <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
